// File: rtl/rd53_reset_sequencer.sv
// rtl/rd53_reset_sequencer.sv - staged POR release sequencer for analog, core and command reset domains
// Optional feature macro: RD53_RESET_SEQ_STATUS_EN (POR_SEEN / POR_COUNT / STATUS_CLR status block)
module rd53_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16,
    parameter int STAGE_GAP     = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       POR_OUT_B,
    input  logic       STATUS_CLR,
    output logic       RST_ANALOG_B,
    output logic       RST_CORE_B,
    output logic       RST_CMD_B,
    output logic       READY,
    output logic       POR_SEEN,
    output logic [3:0] POR_COUNT
);

    typedef enum logic [2:0] {
        HOLD       = 3'd0,
        FILTER     = 3'd1,
        REL_ANALOG = 3'd2,
        REL_CORE   = 3'd3,
        RUN        = 3'd4
    } state_t;

    // Either a block reset or a live POR pulls every domain back into reset at once.
    logic por_clr;
    assign por_clr = RST | ~POR_OUT_B;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   por_s;
    state_t                 state, state_nxt;
    logic [7:0]             cnt, cnt_nxt;

    // POR synchronizer: asynchronous clear, synchronous release.
    always_ff @(posedge CLK or posedge por_clr) begin
        if (por_clr) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], POR_OUT_B};
        end
    end

    assign por_s = sync_q[SYNC_STAGES-1];

    // FSM state and counter; only RST clears them so a POR is seen as a transition.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= HOLD;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter logic for filter and staged release.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            HOLD: begin
                if (por_s) begin
                    state_nxt = FILTER;
                    cnt_nxt   = 8'd1;
                end else begin
                    cnt_nxt   = 8'd0;
                end
            end
            FILTER: begin
                if (!por_s) begin
                    state_nxt = HOLD;
                    cnt_nxt   = 8'd0;
                end else if (cnt == 8'(FILTER_CYCLES)) begin
                    state_nxt = REL_ANALOG;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt   = cnt + 8'd1;
                end
            end
            REL_ANALOG: begin
                if (!por_s) begin
                    state_nxt = HOLD;
                    cnt_nxt   = 8'd0;
                end else if (cnt == 8'(STAGE_GAP - 1)) begin
                    state_nxt = REL_CORE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt   = cnt + 8'd1;
                end
            end
            REL_CORE: begin
                if (!por_s) begin
                    state_nxt = HOLD;
                    cnt_nxt   = 8'd0;
                end else if (cnt == 8'(STAGE_GAP - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt   = cnt + 8'd1;
                end
            end
            RUN: begin
                if (!por_s) begin
                    state_nxt = HOLD;
                    cnt_nxt   = 8'd0;
                end
            end
            default: begin
                state_nxt = HOLD;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Domain resets decode the next state, so each rises on the edge its stage is entered;
    // the nested decode keeps analog -> core -> cmd ordering by construction.
    always_ff @(posedge CLK or posedge por_clr) begin
        if (por_clr) begin
            RST_ANALOG_B <= 1'b0;
            RST_CORE_B   <= 1'b0;
            RST_CMD_B    <= 1'b0;
            READY        <= 1'b0;
        end else begin
            RST_ANALOG_B <= (state_nxt == REL_ANALOG) || (state_nxt == REL_CORE) || (state_nxt == RUN);
            RST_CORE_B   <= (state_nxt == REL_CORE) || (state_nxt == RUN);
            RST_CMD_B    <= (state_nxt == RUN);
            READY        <= (state_nxt == RUN);
        end
    end

`ifdef RD53_RESET_SEQ_STATUS_EN
    // A POR event is a drop back to HOLD after the filter passed; filter glitches do not count.
    logic por_event;
    assign por_event = ((state == REL_ANALOG) || (state == REL_CORE) || (state == RUN))
                       && (state_nxt == HOLD);

    // Sticky status survives POR; an event coincident with a clear wins and counts as one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            POR_SEEN  <= 1'b0;
            POR_COUNT <= 4'd0;
        end else if (por_event) begin
            POR_SEEN  <= 1'b1;
            if (STATUS_CLR) begin
                POR_COUNT <= 4'd1;
            end else if (POR_COUNT != 4'd15) begin
                POR_COUNT <= POR_COUNT + 4'd1;
            end
        end else if (STATUS_CLR) begin
            POR_SEEN  <= 1'b0;
            POR_COUNT <= 4'd0;
        end
    end
`else
    logic unused_status_clr;
    assign unused_status_clr = STATUS_CLR;
    assign POR_SEEN          = 1'b0;
    assign POR_COUNT         = 4'd0;
`endif

endmodule
